// File: rtl/req_ack_pkg.sv
// Shared defaults and entry type for the req/ack responder.
package req_ack_pkg;
   localparam int LATENCY_MAX         = 8;
   localparam int DEF_LATENCY         = 2;
   localparam int DEF_MAX_PENDING     = 4;
   localparam int DEF_TAG_W           = 4;
   localparam int DEF_CNT_W           = 8;

   typedef struct packed {
      logic                 valid;
      logic [DEF_TAG_W-1:0] tag;
   } req_entry_t;
endpackage

// File: rtl/resp_fifo.sv
// In-order FIFO holding matured requests whose ack was stalled.
// A push is accepted when full only if a pop happens on the same edge.
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/req_ack_responder.sv
// Answers each sampled request with a same-tag ack LATENCY cycles later,
// buffering matured requests in order while acks are held off.
module req_ack_responder
   import req_ack_pkg::*;
#(
   parameter int LATENCY     = DEF_LATENCY,
   parameter int MAX_PENDING = DEF_MAX_PENDING,
   parameter int TAG_W       = DEF_TAG_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_i,
   input  logic [TAG_W-1:0]             req_tag_i,
   input  logic                         hold_i,
   output logic                         ack_o,
   output logic [TAG_W-1:0]             ack_tag_o,
   output logic [$clog2(MAX_PENDING):0] pending_o,
   output logic                         overflow_o,
   output logic [CNT_W-1:0]             req_cnt_o,
   output logic [CNT_W-1:0]             ack_cnt_o
);
   logic             dl_valid [LATENCY];
   logic [TAG_W-1:0] dl_tag   [LATENCY];
   logic             m_valid;
   logic [TAG_W-1:0] m_tag;
   logic             bypass;
   logic             fifo_push;
   logic             fifo_pop;
   logic [TAG_W-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            dl_valid[i] <= 1'b0;
            dl_tag[i]   <= '0;
         end
      end else begin
         dl_valid[0] <= req_i;
         dl_tag[0]   <= req_tag_i;
         for (int i = 1; i < LATENCY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_tag[i]   <= dl_tag[i-1];
         end
      end
   end

   assign m_valid = dl_valid[LATENCY-1];
   assign m_tag   = dl_tag[LATENCY-1];

   // Buffered entries are older than the matured request, so they win.
   always_comb begin
      ack_o     = 1'b0;
      ack_tag_o = '0;
      bypass    = 1'b0;
      if (!hold_i) begin
         if (!fifo_empty) begin
            ack_o     = 1'b1;
            ack_tag_o = fifo_head;
         end else if (m_valid) begin
            ack_o     = 1'b1;
            ack_tag_o = m_tag;
            bypass    = 1'b1;
         end
      end
   end

   assign fifo_pop  = ack_o && !fifo_empty;
   assign fifo_push = m_valid && !bypass;

   resp_fifo #(
      .DEPTH (MAX_PENDING),
      .WIDTH (TAG_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (m_tag),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (pending_o),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_o <= 1'b0;
         req_cnt_o  <= '0;
         ack_cnt_o  <= '0;
      end else begin
         if (fifo_push && fifo_full && !fifo_pop) overflow_o <= 1'b1;
         if (req_i) req_cnt_o <= req_cnt_o + 1'b1;
         if (ack_o) ack_cnt_o <= ack_cnt_o + 1'b1;
      end
   end
endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench for req_ack_responder with a queue-based reference model.
module tb_req_ack_responder;
   import req_ack_pkg::*;

   localparam int L  = 2;
   localparam int MP = 4;
   localparam int TW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_i;
   logic [TW-1:0] req_tag_i;
   logic          hold_i;
   logic          ack_o;
   logic [TW-1:0] ack_tag_o;
   logic [$clog2(MP):0] pending_o;
   logic          overflow_o;
   logic [CW-1:0] req_cnt_o;
   logic [CW-1:0] ack_cnt_o;

   req_ack_responder #(
      .LATENCY (L), .MAX_PENDING (MP), .TAG_W (TW), .CNT_W (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .req_tag_i  (req_tag_i),
      .hold_i     (hold_i),
      .ack_o      (ack_o),
      .ack_tag_o  (ack_tag_o),
      .pending_o  (pending_o),
      .overflow_o (overflow_o),
      .req_cnt_o  (req_cnt_o),
      .ack_cnt_o  (ack_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: requests in flight stamped with the edge that sampled
   // them, a pending queue, and expected acks for the monitor.
   typedef struct {
      logic [TW-1:0] tag;
      int            s;
   } flight_t;

   flight_t       inflight[$];
   logic [TW-1:0] pend[$];
   logic [TW-1:0] exp_q[$];
   int            m_req_cnt = 0;
   int            m_ack_cnt = 0;
   logic          m_ovf = 1'b0;
   int            now = 0;
   logic          mv, ak;
   logic [TW-1:0] mt, at;
   flight_t       fe;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight.delete();
         pend.delete();
         m_req_cnt = 0;
         m_ack_cnt = 0;
         m_ovf     = 1'b0;
      end else begin
         mv = 1'b0; mt = '0; ak = 1'b0; at = '0;
         if (inflight.size() > 0 && inflight[0].s + L == now) begin
            fe = inflight.pop_front();
            mv = 1'b1;
            mt = fe.tag;
         end
         if (!hold_i) begin
            if (pend.size() > 0) begin
               ak = 1'b1;
               at = pend.pop_front();
            end else if (mv) begin
               ak = 1'b1;
               at = mt;
               mv = 1'b0;
            end
         end
         if (ak) begin
            exp_q.push_back(at);
            m_ack_cnt++;
         end
         if (mv) begin
            if (pend.size() < MP) pend.push_back(mt);
            else m_ovf = 1'b1;
         end
         if (req_i) begin
            fe.tag = req_tag_i;
            fe.s   = now;
            inflight.push_back(fe);
            m_req_cnt++;
         end
         now++;
      end
   end

   // Ack monitor: consumes one expected ack whenever the DUT acks.
   logic [TW-1:0] et;
   always begin
      @(negedge clk);
      #1;
      if (ack_o) begin
         if (exp_q.size() == 0) chk("spurious_ack", ack_o, 1'b0);
         else begin
            et = exp_q.pop_front();
            chk("ack_tag", ack_tag_o, et);
         end
      end else begin
         if (exp_q.size() > 0) begin
            et = exp_q.pop_front();
            chk("ack_missing", ack_o, 1'b1);
         end else begin
            chk("idle_ack_tag", ack_tag_o, '0);
         end
      end
   end

   // Status monitor for registered outputs.
   always begin
      @(posedge clk);
      #3;
      chk("pending",  pending_o,  pend.size());
      chk("overflow", overflow_o, m_ovf);
      chk("req_cnt",  req_cnt_o,  m_req_cnt[CW-1:0]);
      chk("ack_cnt",  ack_cnt_o,  m_ack_cnt[CW-1:0]);
   end

   // Drives one cycle's inputs; called at posedge+1.
   task automatic cyc(input logic r, input logic [TW-1:0] t, input logic h);
      req_i     = r;
      req_tag_i = t;
      hold_i    = h;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req_i = 1'b0; req_tag_i = '0; hold_i = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_ack", ack_o, 1'b0);
      chk("reset_pending", pending_o, 0);

      // Single request
      repeat (8) cyc(1'b0, '0, 1'b0);
      cyc(1'b1, 4'h3, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b0);
      chk("t1_req_cnt", req_cnt_o, 1);
      chk("t1_ack_cnt", ack_cnt_o, 1);

      // Back-to-back requests
      for (int i = 1; i <= 5; i++) cyc(1'b1, TW'(i), 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b0);

      // Hold while four mature, then release
      cyc(1'b1, 4'hA, 1'b1); cyc(1'b1, 4'hB, 1'b1);
      cyc(1'b1, 4'hC, 1'b1); cyc(1'b1, 4'hD, 1'b1);
      cyc(1'b0, '0, 1'b1);   cyc(1'b0, '0, 1'b1);
      chk("t3_pending", pending_o, 4);
      chk("t3_overflow", overflow_o, 1'b0);
      repeat (6) cyc(1'b0, '0, 1'b0);
      chk("t3_drained", pending_o, 0);

      // Fifth matured request while full and held
      for (int i = 6; i <= 10; i++) cyc(1'b1, TW'(i), 1'b1);
      repeat (2) cyc(1'b0, '0, 1'b1);
      chk("t4_pending", pending_o, 4);
      chk("t4_overflow", overflow_o, 1'b1);
      repeat (6) cyc(1'b0, '0, 1'b0);
      chk("t4_sticky", overflow_o, 1'b1);

      // Reset with three pending and two in the delay line
      cyc(1'b1, 4'h1, 1'b1); cyc(1'b1, 4'h2, 1'b1); cyc(1'b1, 4'h3, 1'b1);
      cyc(1'b0, '0, 1'b1);   cyc(1'b0, '0, 1'b1);
      cyc(1'b1, 4'h4, 1'b1); cyc(1'b1, 4'h5, 1'b1);
      chk("t6_pre_pending", pending_o, 3);
      req_i = 1'b0; hold_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("t6_ack", ack_o, 1'b0);
      chk("t6_ack_tag", ack_tag_o, '0);
      chk("t6_pending", pending_o, 0);
      chk("t6_overflow", overflow_o, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 4'h7, 1'b0);
      repeat (4) cyc(1'b0, '0, 1'b0);
      chk("t6_req_cnt", req_cnt_o, 1);
      chk("t6_ack_cnt", ack_cnt_o, 1);

      // Full buffer with simultaneous push and pop
      for (int i = 0; i < 12; i++) cyc(1'b1, TW'(i + 1), (i < 6));
      chk("t5_pending", pending_o, 4);
      chk("t5_overflow", overflow_o, 1'b0);
      repeat (8) cyc(1'b0, '0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0));
      repeat (12) cyc(1'b0, '0, 1'b0);
      chk("final_pending", pending_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
